// File: rtl/axis_packer_if.sv
// Bus bundle for axis_packer: narrow pixel stream in, wide chunk stream out.
// The slave modport is the packer's view; master is the surrounding environment.
interface axis_packer_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 128
);
  localparam int unsigned RATIO = OUT_W / IN_W;

  logic             pixel_tvalid;
  logic             pixel_tready;
  logic [IN_W-1:0]  pixel_tdata;
  logic             pixel_tlast;

  logic             chunk_tvalid;
  logic             chunk_tready;
  logic [OUT_W-1:0] chunk_tdata;
  logic [RATIO-1:0] chunk_tkeep;
  logic             chunk_tlast;

  modport slave (
    input  pixel_tvalid, pixel_tdata, pixel_tlast, chunk_tready,
    output pixel_tready, chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast
  );

  modport master (
    output pixel_tvalid, pixel_tdata, pixel_tlast, chunk_tready,
    input  pixel_tready, chunk_tvalid, chunk_tdata, chunk_tkeep, chunk_tlast
  );
endinterface

// File: rtl/axis_packer.sv
// Packs IN_W-bit words LSB-first into OUT_W-bit chunks, with early close on tlast
// or on an explicit flush; one-entry output register decoupled from assembly.
module axis_packer #(
  parameter int unsigned IN_W          = 16,
  parameter int unsigned OUT_W         = 128,
  parameter bit          FLUSH_ON_LAST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  axis_packer_if.slave  axis,
  input  logic          flush,
  output logic [31:0]   chunk_count
);
  localparam int unsigned RATIO = OUT_W / IN_W;
  localparam int unsigned CW    = $clog2(RATIO);
  localparam logic [CW-1:0] FillMax = CW'(RATIO - 1);

  logic [OUT_W-1:0] asm_q, asm_d, asm_ins;
  logic [CW-1:0]    fill_q, fill_d;
  logic             asm_last_q, asm_last_d, last_ins;
  logic             pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic [31:0]      count_q, count_d;

  logic        out_free, would_close, ready, accept, close_word, close_flush;
  int unsigned fill_n;

  function automatic logic [RATIO-1:0] keep_mask(input int unsigned n);
    logic [RATIO-1:0] m;
    for (int unsigned k = 0; k < RATIO; k++) m[k] = (k < n);
    return m;
  endfunction

  always_comb begin
    out_free    = !out_valid_q || axis.chunk_tready;
    would_close = (fill_q == FillMax) || (FLUSH_ON_LAST && axis.pixel_tlast);
    // A word that would close a chunk needs somewhere to land this cycle.
    ready       = !rst && !pend_q && (out_free || !would_close);
    accept      = axis.pixel_tvalid && ready;
    close_word  = accept && would_close;
    close_flush = pend_q && (fill_q != '0) && out_free;
    fill_n      = 32'(fill_q);

    asm_ins = asm_q;
    if (accept) asm_ins[fill_n*IN_W +: IN_W] = axis.pixel_tdata;
    last_ins = asm_last_q || (accept && axis.pixel_tlast);

    asm_d       = asm_ins;
    fill_d      = fill_q;
    asm_last_d  = last_ins;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    if (accept) fill_d = fill_q + 1'b1;
    if (out_valid_q && axis.chunk_tready) out_valid_d = 1'b0;

    if (close_word || close_flush) begin
      out_valid_d = 1'b1;
      out_data_d  = asm_ins;
      out_keep_d  = keep_mask(close_word ? fill_n + 1 : fill_n);
      out_last_d  = last_ins;
      asm_d       = '0;
      fill_d      = '0;
      asm_last_d  = 1'b0;
    end

    // An empty assembly at flush time retires the request without emitting.
    pend_d  = (pend_q && !((fill_q == '0) || close_flush)) || flush;
    count_d = count_q + 32'(out_valid_q && axis.chunk_tready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= '0;
      fill_q      <= '0;
      asm_last_q  <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      asm_q       <= asm_d;
      fill_q      <= fill_d;
      asm_last_q  <= asm_last_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
    end
  end

  assign axis.pixel_tready = ready;
  assign axis.chunk_tvalid = out_valid_q;
  assign axis.chunk_tdata  = out_data_q;
  assign axis.chunk_tkeep  = out_keep_q;
  assign axis.chunk_tlast  = out_last_q;
  assign chunk_count       = count_q;
endmodule

// File: doc/axis_packer.md
AXIS_PACKER -- requirements
Module: axis_packer

Interface
REQ-001 SHALL have parameter IN_W, default 16, input word width in bits.
REQ-002 SHALL have parameter OUT_W, default 128, output chunk width in bits; OUT_W/IN_W (RATIO) is a power of two, at least 2.
REQ-003 SHALL have parameter FLUSH_ON_LAST, default 1; 1 = an accepted pixel_tlast closes the current chunk; 0 = chunks always hold RATIO words.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pixel_tvalid  input  1  input word valid.
REQ-007 pixel_tready  output  1  input word accepted when tvalid && tready.
REQ-008 pixel_tdata  input  IN_W  input word.
REQ-009 pixel_tlast  input  1  last word of packet.
REQ-010 flush  input  1  single-cycle request to emit a partially filled chunk.
REQ-011 chunk_tvalid  output  1  output chunk valid.
REQ-012 chunk_tready  input  1  downstream accepts when tvalid && tready.
REQ-013 chunk_tdata  output  OUT_W  packed chunk.
REQ-014 chunk_tkeep  output  RATIO  one bit per word slot; 1 = slot holds a real word.
REQ-015 chunk_tlast  output  1  chunk ends a packet.
REQ-016 chunk_count  output  32  number of chunks accepted downstream; wraps modulo 2^32.

Function
REQ-017 SHALL pack words least-significant first: word k of a chunk in bits [(k+1)*IN_W-1 : k*IN_W].
REQ-018 SHALL hold words in an assembly register with fill counter 0..RATIO-1, separate from a one-entry output register driving the chunk_* outputs.
REQ-019 Closing event: accepted word at fill RATIO-1; accepted word with pixel_tlast when FLUSH_ON_LAST=1; or a pending flush with fill>0.
REQ-020 On a closing event the assembled chunk SHALL load into the output register, with chunk_tvalid high the following cycle (latency 1 from the closing beat); fill returns to 0.
REQ-021 Unfilled slots SHALL be zero in chunk_tdata with their chunk_tkeep bits 0; full chunks carry all-ones chunk_tkeep.
REQ-022 chunk_tlast SHALL be 1 iff any word in the chunk was accepted with pixel_tlast.
REQ-023 pixel_tready SHALL be 1 except when (a) the next word would close a chunk and the output register is occupied and not being accepted this cycle, or (b) a flush is pending.
REQ-024 Output register is free when chunk_tvalid=0 or chunk_tready=1 in the same cycle; with chunk_tready held high, sustained throughput is one chunk per RATIO cycles with no bubbles.
REQ-025 chunk_tdata, chunk_tkeep and chunk_tlast SHALL stay stable while chunk_tvalid=1 and chunk_tready=0.
REQ-026 flush SHALL set a pending bit; the pending bit clears when the partial chunk loads into the output register, or immediately if fill=0 (no empty chunk emitted).
REQ-027 A word accepted in the same cycle flush is asserted SHALL be included in the flushed chunk. If that word itself closes the chunk, the flush finds fill=0 and clears without emitting.
REQ-028 A flush arriving while the output register is occupied SHALL remain pending, with pixel_tready=0, until the register frees.
REQ-029 With FLUSH_ON_LAST=0, pixel_tlast SHALL only affect chunk_tlast; chunks are emitted only when full or on flush.
REQ-030 chunk_count SHALL increment by 1 on each cycle with chunk_tvalid && chunk_tready.

Reset
REQ-031 While rst=1: chunk_tvalid=0, chunk_tdata=0, chunk_tkeep=0, chunk_tlast=0, chunk_count=0, fill=0, flush pending=0, assembly register=0.
REQ-032 pixel_tready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-033 Reset mid-packet SHALL discard partial assembly and any held output chunk without emitting it.

Verification
REQ-034 Defaults, chunk_tready=1, 8 consecutive words 0x0001..0x0008: one chunk 0x0008_0007_..._0001, tkeep=0xFF, tlast=0, valid one cycle after the 8th word; chunk_count=1.
REQ-035 Defaults, 3 words 0xA,0xB,0xC with tlast on 0xC: chunk_tdata=0x...000C_000B_000A (upper zeros), tkeep=0x07, tlast=1.
REQ-036 chunk_tready=0 with one chunk held, 16 more words offered: first 7 accepted, 8th stalls (pixel_tready=0), held data stable; release tready -> second chunk follows on the next cycle, nothing lost.
REQ-037 5 words, then flush while output busy: pixel_tready=0 until free, then tkeep=0x1F chunk; flush with fill=0 emits nothing.
REQ-038 FLUSH_ON_LAST=0, IN_W=32, OUT_W=64: tlast on word 1 -> no emission until word 2; chunk tkeep=0x3, tlast=1.
REQ-039 rst pulsed after 4 words: no chunk emitted; next 8 words form a clean chunk starting at slot 0.
